turnstile_bank_ctrl: RTL and testbench
======================================

// Module: turnstile_bank_ctrl
// PURPOSE
//   Parametrised successor of the single-gate pay/turn automaton. Controls NUM_GATES independent lanes.
//   Each lane has registered state, a saturating prepaid-credit counter and forced-passage alarm detection.
//   One shared wrapping passage counter. Sits between coin/turn sensor logic and the gate actuators.
// PARAMETERS
//   NUM_GATES   4    number of lanes (>=1)
//   CREDIT_W    3    per-lane credit counter width; CMAX = 2**CREDIT_W-1
//   COUNT_W     16   width of the shared passage counter (wraps)
//   TIMEOUT_CYC 100  cycles OPENED without a turn before auto-close (only with TURNSTILE_TIMEOUT_EN)
// PORTS
//   clk         in   1              clock, all state on posedge
//   rst         in   1              asynchronous, active-high reset
//   pay         in   NUM_GATES      per-lane pay pulse (1 cycle = 1 credit)
//   turn        in   NUM_GATES      per-lane arm-rotation pulse
//   clrAlarm    in   NUM_GATES      per-lane alarm acknowledge
//   gateState   out  2*NUM_GATES    lane i state at [2i+1:2i]: 00 CLOSED, 01 OPENED, 10 ALARM
//   gateOpen    out  NUM_GATES      1 when lane state == OPENED
//   alarm       out  NUM_GATES      1 when lane state == ALARM
//   credit      out  CREDIT_W*NUM_GATES  lane i credit at [CREDIT_W*i +: CREDIT_W]
//   payReject   out  NUM_GATES      1-cycle pulse: pay dropped because credit was CMAX
//   timeoutHit  out  NUM_GATES      1-cycle pulse: lane auto-closed on timeout (0 without macro)
//   passCount   out  COUNT_W        total legitimate passages, all lanes
// BEHAVIOUR
//   - All outputs are registered. 1-cycle latency from sampled input to output.
//   - Reset (async assert, sync release): every lane CLOSED, credit 0, pulses 0, passCount 0, timers 0.
//   - Credit per cycle: next = credit + pay_acc - turn_acc.
//     - pay_acc = pay && credit != CMAX. A pay at CMAX pulses payReject and leaves credit at CMAX.
//     - turn_acc = turn && state == OPENED.
//   - CLOSED:
//     - turn -> ALARM. Any pay in that cycle is still accepted.
//     - else credit + pay_acc > 0 -> OPENED.
//     - else stay CLOSED.
//   - OPENED:
//     - turn -> credit-1+pay_acc; passCount+1.
//     - If the resulting credit is 0 -> CLOSED, else stay OPENED.
//     - Pay and turn in the same cycle: credit unchanged, stay OPENED.
//   - ALARM:
//     - turn ignored; pay accepted into credit.
//     - clrAlarm -> CLOSED. The lane reopens on the next cycle if credit > 0.
//     - clrAlarm in CLOSED/OPENED is ignored.
//   - passCount adds the popcount of turn_acc across all lanes each cycle (simultaneous passages all
//     counted); wraps modulo 2**COUNT_W.
//   - Lanes are fully independent; no arbitration between lanes.
//   - Async reset mid-operation discards credit and alarm immediately; no pulses on release.
// CONFIGURATION
//   TURNSTILE_TIMEOUT_EN defined:
//     - Per-lane idle timer, $clog2(TIMEOUT_CYC+1) bits, cleared on entering OPENED and on any pay/turn.
//     - Trigger: lane OPENED for TIMEOUT_CYC consecutive cycles with no pay and no turn.
//     - At that edge: state -> CLOSED, credit -> 0, timeoutHit[i] pulses one cycle.
//     - A pay or turn arriving in the trigger cycle wins; no timeout.
//   TURNSTILE_TIMEOUT_EN undefined: no timers; timeoutHit tied 0; OPENED persists until credit is used.
// TESTING
//   1 reset: rst=1 mid-sim with credit 3 on lane0 -> all outputs 0 / CLOSED immediately, before the clock edge.
//   2 lane0 pay x1 -> gateOpen[0]=1 one cycle later, credit0=1;
//     turn -> CLOSED, credit0=0, passCount=1.
//   3 lane1 pay x7 then pay -> credit1=7, payReject[1] pulses once;
//     7 turns -> passCount=7, lane1 CLOSED.
//   4 lane2 CLOSED, turn -> ALARM, alarm[2]=1; further turn ignored;
//     pay -> credit2=1; clrAlarm -> CLOSED, next cycle OPENED.
//   5 lanes0..3 all OPENED credit 1, turn=4'b1111 same cycle -> passCount +4, all CLOSED;
//     preload passCount 16'hFFFE, two passages -> 16'h0000.
//   6 TURNSTILE_TIMEOUT_EN, TIMEOUT_CYC=10: lane3 credit 2, idle 10 cycles -> CLOSED, credit3=0, timeoutHit[3] one pulse;
//     repeat with pay on cycle 10 -> no timeout, credit3=3.

Source files
------------

// File: rtl/turnstile_bank_ctrl.sv
// Multi-lane turnstile controller: per-lane CLOSED/OPENED/ALARM automaton, saturating credit, shared passage counter.
// Optional idle auto-close when TURNSTILE_TIMEOUT_EN is defined.
module turnstile_bank_ctrl #(
    parameter int unsigned NUM_GATES   = 4,
    parameter int unsigned CREDIT_W    = 3,
    parameter int unsigned COUNT_W     = 16,
    parameter int unsigned TIMEOUT_CYC = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_GATES-1:0]          pay,
    input  logic [NUM_GATES-1:0]          turn,
    input  logic [NUM_GATES-1:0]          clrAlarm,
    output logic [2*NUM_GATES-1:0]        gateState,
    output logic [NUM_GATES-1:0]          gateOpen,
    output logic [NUM_GATES-1:0]          alarm,
    output logic [CREDIT_W*NUM_GATES-1:0] credit,
    output logic [NUM_GATES-1:0]          payReject,
    output logic [NUM_GATES-1:0]          timeoutHit,
    output logic [COUNT_W-1:0]            passCount
);

    typedef enum logic [1:0] {
        CLOSED = 2'b00,
        OPENED = 2'b01,
        ALARM  = 2'b10
    } lane_state_e;

    localparam logic [CREDIT_W-1:0] CMAX = '1;

    if (NUM_GATES < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("turnstile_bank_ctrl: NUM_GATES and TIMEOUT_CYC must be at least 1");
    end

    lane_state_e          state_q  [NUM_GATES];
    lane_state_e          state_d  [NUM_GATES];
    logic [CREDIT_W-1:0]  credit_q [NUM_GATES];
    logic [CREDIT_W-1:0]  credit_d [NUM_GATES];
    logic [NUM_GATES-1:0] open_q, alarm_q;
    logic [NUM_GATES-1:0] reject_q, reject_d;
    logic [NUM_GATES-1:0] timeout_q, timeout_d;
    logic [COUNT_W-1:0]   pass_q, pass_d;

`ifdef TURNSTILE_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] timer_q [NUM_GATES];
    logic [TMR_W-1:0] timer_d [NUM_GATES];
`endif

    always_comb begin
        logic pay_acc;
        logic turn_acc;
        pay_acc   = 1'b0;
        turn_acc  = 1'b0;
        pass_d    = pass_q;
        reject_d  = '0;
        timeout_d = '0;
        for (int unsigned i = 0; i < NUM_GATES; i++) begin
            pay_acc     = pay[i] && (credit_q[i] != CMAX);
            turn_acc    = turn[i] && (state_q[i] == OPENED);
            reject_d[i] = pay[i] && (credit_q[i] == CMAX);
            credit_d[i] = credit_q[i] + CREDIT_W'(pay_acc) - CREDIT_W'(turn_acc);
            state_d[i]  = state_q[i];
            pass_d      = pass_d + COUNT_W'(turn_acc);

            // A CLOSED lane never accepts a turn, so credit_d already holds credit + pay_acc there.
            unique case (state_q[i])
                CLOSED: begin
                    if (turn[i])
                        state_d[i] = ALARM;
                    else if (credit_d[i] != '0)
                        state_d[i] = OPENED;
                end
                OPENED: begin
                    if (credit_d[i] == '0)
                        state_d[i] = CLOSED;
                end
                ALARM: begin
                    if (clrAlarm[i])
                        state_d[i] = CLOSED;
                end
                default: state_d[i] = CLOSED;
            endcase

`ifdef TURNSTILE_TIMEOUT_EN
            // Timer is held at zero outside OPENED, which covers the clear-on-entry rule.
            timer_d[i] = '0;
            if (state_q[i] == OPENED && !pay[i] && !turn[i]) begin
                if (timer_q[i] == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_d[i]   = CLOSED;
                    credit_d[i]  = '0;
                    timeout_d[i] = 1'b1;
                end else begin
                    timer_d[i] = timer_q[i] + 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_GATES; i++) begin
                state_q[i]  <= CLOSED;
                credit_q[i] <= '0;
`ifdef TURNSTILE_TIMEOUT_EN
                timer_q[i]  <= '0;
`endif
            end
            open_q    <= '0;
            alarm_q   <= '0;
            reject_q  <= '0;
            timeout_q <= '0;
            pass_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_GATES; i++) begin
                state_q[i]  <= state_d[i];
                credit_q[i] <= credit_d[i];
                open_q[i]   <= (state_d[i] == OPENED);
                alarm_q[i]  <= (state_d[i] == ALARM);
`ifdef TURNSTILE_TIMEOUT_EN
                timer_q[i]  <= timer_d[i];
`endif
            end
            reject_q  <= reject_d;
            timeout_q <= timeout_d;
            pass_q    <= pass_d;
        end
    end

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_pack
        assign gateState[2*g +: 2]             = state_q[g];
        assign credit[CREDIT_W*g +: CREDIT_W] = credit_q[g];
    end

    assign gateOpen   = open_q;
    assign alarm      = alarm_q;
    assign payReject  = reject_q;
    assign timeoutHit = timeout_q;
    assign passCount  = pass_q;

endmodule

// File: tb/tb_turnstile_bank_ctrl.sv
// Bench for turnstile_bank_ctrl: behavioural lane model checked every cycle, directed scenarios, random traffic.
// Timeout scenario runs only when TURNSTILE_TIMEOUT_EN is defined.
module tb_turnstile_bank_ctrl;

    localparam int NG   = 4;
    localparam int CW   = 3;
    localparam int PW   = 16;
    localparam int TO   = 10;
    localparam int CMAX = (1 << CW) - 1;
    localparam int ST_CL = 0, ST_OP = 1, ST_AL = 2;

    logic              clk;
    logic              rst;
    logic [NG-1:0]     pay, turn, clr;
    logic [2*NG-1:0]   gateState;
    logic [NG-1:0]     gateOpen, alarm, payReject, timeoutHit;
    logic [CW*NG-1:0]  credit;
    logic [PW-1:0]     passCount;

    int errors = 0;
    int checks = 0;

    turnstile_bank_ctrl #(
        .NUM_GATES  (NG),
        .CREDIT_W   (CW),
        .COUNT_W    (PW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pay       (pay),
        .turn      (turn),
        .clrAlarm  (clr),
        .gateState (gateState),
        .gateOpen  (gateOpen),
        .alarm     (alarm),
        .credit    (credit),
        .payReject (payReject),
        .timeoutHit(timeoutHit),
        .passCount (passCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int lane, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s lane %0d: got 'h%0h expected 'h%0h at %0t", name, lane, act, exp, $time);
        end
    endtask

    // Reference model: lane rules applied with plain integers.
    int m_state [NG] = '{default: 0};
    int m_credit[NG] = '{default: 0};
    int m_idle  [NG] = '{default: 0};
    bit m_rej   [NG] = '{default: 0};
    bit m_to    [NG] = '{default: 0};
    int m_pass = 0;

    always @(posedge clk or posedge rst) begin : model
        int passages;
        int c;
        bit p, t, acc;
        if (rst) begin
            for (int i = 0; i < NG; i++) begin
                m_state[i] = ST_CL; m_credit[i] = 0; m_idle[i] = 0;
                m_rej[i] = 0; m_to[i] = 0;
            end
            m_pass = 0;
        end else begin
            passages = 0;
            for (int i = 0; i < NG; i++) begin
                c   = m_credit[i];
                p   = pay[i];
                t   = turn[i];
                acc = p && (c < CMAX);
                m_rej[i] = p && !acc;
                m_to[i]  = 0;
                case (m_state[i])
                    ST_CL: begin
                        c += int'(acc);
                        if (t) m_state[i] = ST_AL;
                        else if (c > 0) begin m_state[i] = ST_OP; m_idle[i] = 0; end
                    end
                    ST_OP: begin
                        if (t) begin
                            passages++;
                            c = c + int'(acc) - 1;
                            if (c == 0) m_state[i] = ST_CL;
                        end else begin
                            c += int'(acc);
                        end
`ifdef TURNSTILE_TIMEOUT_EN
                        if (p || t) m_idle[i] = 0;
                        else begin
                            m_idle[i]++;
                            if (m_idle[i] == TO) begin
                                m_state[i] = ST_CL; c = 0; m_to[i] = 1;
                            end
                        end
`endif
                    end
                    default: begin
                        c += int'(acc);
                        if (clr[i]) m_state[i] = ST_CL;
                    end
                endcase
                m_credit[i] = c;
            end
            m_pass = (m_pass + passages) % (1 << PW);
        end
    end

    always @(posedge clk) begin : compare
        #1;
        if (rst === 1'b0) begin
            for (int i = 0; i < NG; i++) begin
                check("gateState",  i, gateState[2*i +: 2],  m_state[i]);
                check("gateOpen",   i, gateOpen[i],          m_state[i] == ST_OP);
                check("alarm",      i, alarm[i],             m_state[i] == ST_AL);
                check("credit",     i, credit[CW*i +: CW],   m_credit[i]);
                check("payReject",  i, payReject[i],         m_rej[i]);
                check("timeoutHit", i, timeoutHit[i],        m_to[i]);
            end
            check("passCount", -1, passCount, m_pass);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int pp, tp, cp;
        rst = 1'b1; pay = '0; turn = '0; clr = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        step();
        check("rst_state",  -1, gateState, 0);
        check("rst_credit", -1, credit, 0);
        check("rst_pass",   -1, passCount, 0);

        // single pay opens lane0, one turn closes it
        pay = 4'b0001; step(); pay = '0;
        check("pay_open",   0, gateOpen, 4'b0001);
        check("pay_credit", 0, credit[2:0], 1);
        turn = 4'b0001; step(); turn = '0;
        check("turn_close", 0, gateState, 0);
        check("turn_credit", 0, credit, 0);
        check("turn_pass",  0, passCount, 1);

        // lane1 saturation and drain
        pay = 4'b0010; step(7);
        check("sat_credit", 1, credit[5:3], 7);
        check("sat_norej",  1, payReject, 0);
        step(); pay = '0;
        check("sat_reject", 1, payReject, 4'b0010);
        check("sat_hold",   1, credit[5:3], 7);
        step();
        check("rej_pulse",  1, payReject, 0);
        turn = 4'b0010; step(7); turn = '0;
        check("drain_pass",  1, passCount, 8);
        check("drain_state", 1, gateState, 0);

        // lane2 forced passage, alarm behaviour
        turn = 4'b0100; step(); turn = '0;
        check("alarm_set",   2, alarm, 4'b0100);
        check("alarm_state", 2, gateState, 8'h20);
        turn = 4'b0100; step(); turn = '0;
        check("alarm_turn",  2, alarm, 4'b0100);
        check("alarm_pass",  2, passCount, 8);
        pay = 4'b0100; step(); pay = '0;
        check("alarm_pay",   2, credit[8:6], 1);
        clr = 4'b0100; step(); clr = '0;
        check("alarm_clr",   2, gateState, 0);
        step();
        check("alarm_reopen", 2, gateOpen, 4'b0100);
        turn = 4'b0100; step(); turn = '0;
        check("alarm_use",   2, passCount, 9);

        // simultaneous passages on all lanes
        pay = 4'b1111; step(); pay = '0;
        check("all_open",   -1, gateOpen, 4'b1111);
        check("all_credit", -1, credit, 12'h249);
        turn = 4'b1111; step(); turn = '0;
        check("all_pass",   -1, passCount, 13);
        check("all_closed", -1, gateState, 0);

        // asynchronous reset with credit held
        pay = 4'b0001; step(3); pay = '0;
        check("pre_rst_credit", 0, credit[2:0], 3);
        #3 rst = 1'b1;
        #1;
        check("arst_state",  -1, gateState, 0);
        check("arst_credit", -1, credit, 0);
        check("arst_open",   -1, gateOpen, 0);
        check("arst_pass",   -1, passCount, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        step();
        check("rel_pulses", -1, {payReject, timeoutHit}, 0);

        // random traffic with varying activity levels
        for (int seg = 0; seg < 15; seg++) begin
            pp = $urandom_range(60);
            tp = $urandom_range(50);
            cp = $urandom_range(40);
            for (int cyc = 0; cyc < 200; cyc++) begin
                for (int i = 0; i < NG; i++) begin
                    pay[i]  = ($urandom_range(99) < pp);
                    turn[i] = ($urandom_range(99) < tp);
                    clr[i]  = ($urandom_range(99) < cp);
                end
                step();
            end
        end
        pay = '0; turn = '0; clr = '0;

`ifdef TURNSTILE_TIMEOUT_EN
        do_reset();
        pay = 4'b1000; step(2); pay = '0;
        check("to_open",    3, gateOpen[3], 1);
        check("to_credit",  3, credit[11:9], 2);
        step(9);
        check("to_still",   3, gateOpen[3], 1);
        check("to_nohit",   3, timeoutHit, 0);
        step();
        check("to_closed",  3, gateState[7:6], 0);
        check("to_cleared", 3, credit[11:9], 0);
        check("to_hit",     3, timeoutHit, 4'b1000);
        step();
        check("to_pulse",   3, timeoutHit, 0);
        pay = 4'b1000; step(2); pay = '0;
        step(9);
        pay = 4'b1000; step(); pay = '0;
        check("to_saved",   3, credit[11:9], 3);
        check("to_saved_hit", 3, timeoutHit, 0);
        check("to_saved_open", 3, gateOpen[3], 1);
`endif

        // passage counter wrap
        do_reset();
        pay = 4'b1111; step();
        turn = 4'b1111; step(16383);
        pay = 4'b0011; turn = 4'b0011; step();
        pay = '0; turn = '0;
        check("wrap_pre",  -1, passCount, 16'hFFFE);
        turn = 4'b0011; step(); turn = '0;
        check("wrap_zero", -1, passCount, 16'h0000);
        check("wrap_open", -1, gateOpen, 4'b1100);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
